// File: rtl/cvbs_timing_gen.sv
// Composite-video timing and test-pattern generator: sync/blanking/active luma
// samples with line and field strobes, geometry fully parametrised.
module cvbs_timing_gen #(
  parameter int SW          = 8,
  parameter int H_TOTAL     = 914,
  parameter int H_SYNC      = 56,
  parameter int H_PORCH     = 113,
  parameter int H_FRONT     = 24,
  parameter int EQ_WIDTH    = 28,
  parameter int BROAD_WIDTH = 428,
  parameter int V_TOTAL     = 312,
  parameter int V_BROAD     = 3,
  parameter int V_PRE_EQ    = 2,
  parameter int V_POST_EQ   = 3,
  parameter int SYNC_LEVEL  = 0,
  parameter int BLACK_LEVEL = 77,
  parameter int WHITE_LEVEL = 255,
  parameter int RAMP_SHIFT  = 2
) (
  input  logic          pclk,
  input  logic          rst_n,
  input  logic [1:0]    mode,
  output logic [SW-1:0] sample_out,
  output logic          sol,
  output logic          sof
);

  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int HALF    = H_TOTAL / 2;
  localparam int X0      = H_SYNC + H_PORCH;
  localparam int Y0      = V_BROAD + V_PRE_EQ;
  localparam int ACT_END = H_TOTAL - H_FRONT;
  localparam int A_W     = H_TOTAL - H_SYNC - H_PORCH - H_FRONT;
  localparam int BAR_W   = A_W / 8;
  localparam int STEP    = (WHITE_LEVEL - BLACK_LEVEL) / 7;
  localparam int SUMW    = SW + ((HW > VW) ? HW : VW) + 1;

  typedef enum logic [1:0] {SEG_SYNC, SEG_BACK, SEG_ACTIVE, SEG_FRONT} seg_t;
  typedef enum logic [1:0] {LT_NORMAL, LT_BROAD, LT_EQ} line_t;

  if (H_SYNC + H_PORCH + H_FRONT >= H_TOTAL) begin : g_bad_hgeom
    $error("cvbs_timing_gen: H_SYNC+H_PORCH+H_FRONT must be less than H_TOTAL");
  end
  if (BROAD_WIDTH >= HALF) begin : g_bad_broad
    $error("cvbs_timing_gen: BROAD_WIDTH must be less than H_TOTAL/2");
  end
  if ((H_TOTAL % 2) != 0) begin : g_bad_even
    $error("cvbs_timing_gen: H_TOTAL must be even");
  end

  function automatic line_t decode_line(input logic [VW-1:0] v);
    if (v < VW'(V_BROAD)) begin
      return LT_BROAD;
    end else if ((v < VW'(V_BROAD + V_PRE_EQ)) || (v >= VW'(V_TOTAL - V_POST_EQ))) begin
      return LT_EQ;
    end else begin
      return LT_NORMAL;
    end
  endfunction

  function automatic logic [SW-1:0] sat(input logic [SUMW-1:0] s);
    return (s > SUMW'(WHITE_LEVEL)) ? SW'(WHITE_LEVEL) : s[SW-1:0];
  endfunction

  logic [HW-1:0] r_hcount;
  logic [VW-1:0] r_vcount;
  seg_t          r_seg;
  line_t         r_ltype;
  logic [1:0]    r_mode;
  logic [2:0]    r_bar;
  logic [HW-1:0] r_bar_px;
  logic [SW-1:0] r_sample;
  logic          r_sol;
  logic          r_sof;

  logic            w_h_wrap;
  logic            w_v_wrap;
  logic [VW-1:0]   w_vcount_next;
  logic [HW-1:0]   w_x;
  logic [VW-1:0]   w_y;
  logic [SUMW-1:0] w_ramp_v;
  logic [SUMW-1:0] w_ramp_h;
  logic [SUMW-1:0] w_bars;
  logic            w_broad_pulse;
  logic            w_eq_pulse;
  logic [SW-1:0]   w_pattern;
  logic [SW-1:0]   w_sample;

  assign w_h_wrap      = (r_hcount == HW'(H_TOTAL - 1));
  assign w_v_wrap      = (r_vcount == VW'(V_TOTAL - 1));
  assign w_vcount_next = w_v_wrap ? '0 : r_vcount + VW'(1);
  assign w_x           = r_hcount - HW'(X0);
  assign w_y           = r_vcount - VW'(Y0);
  assign w_ramp_v      = SUMW'(BLACK_LEVEL) + SUMW'(w_y);
  assign w_ramp_h      = SUMW'(BLACK_LEVEL) + SUMW'(w_x >> RAMP_SHIFT);
  assign w_bars        = SUMW'(WHITE_LEVEL) - SUMW'(r_bar) * SUMW'(STEP);

  // Vertical lines carry two serration pulses, one per half line.
  assign w_broad_pulse = (r_hcount < HW'(BROAD_WIDTH)) ||
                         ((r_hcount >= HW'(HALF)) && (r_hcount < HW'(HALF + BROAD_WIDTH)));
  assign w_eq_pulse    = (r_hcount < HW'(EQ_WIDTH)) ||
                         ((r_hcount >= HW'(HALF)) && (r_hcount < HW'(HALF + EQ_WIDTH)));

  // Pattern selection for the active segment of a normal line.
  always_comb begin
    w_pattern = SW'(BLACK_LEVEL);
    case (r_mode)
      2'd0:    w_pattern = SW'(BLACK_LEVEL);
      2'd1:    w_pattern = sat(w_ramp_v);
      2'd2:    w_pattern = sat(w_ramp_h);
      2'd3:    w_pattern = sat(w_bars);
      default: w_pattern = SW'(BLACK_LEVEL);
    endcase
  end

  // Sample value for the current counter position.
  always_comb begin
    w_sample = SW'(BLACK_LEVEL);
    case (r_ltype)
      LT_BROAD: w_sample = w_broad_pulse ? SW'(SYNC_LEVEL) : SW'(BLACK_LEVEL);
      LT_EQ:    w_sample = w_eq_pulse ? SW'(SYNC_LEVEL) : SW'(BLACK_LEVEL);
      LT_NORMAL: begin
        case (r_seg)
          SEG_SYNC:   w_sample = SW'(SYNC_LEVEL);
          SEG_ACTIVE: w_sample = w_pattern;
          default:    w_sample = SW'(BLACK_LEVEL);
        endcase
      end
      default:  w_sample = SW'(BLACK_LEVEL);
    endcase
  end

  // Raster counters, per-line type decode and per-field mode latch.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_hcount <= '0;
      r_vcount <= '0;
      r_ltype  <= LT_BROAD;
      r_mode   <= 2'd0;
    end else begin
      if (w_h_wrap) begin
        r_hcount <= '0;
        r_vcount <= w_vcount_next;
        r_ltype  <= decode_line(w_vcount_next);
      end else begin
        r_hcount <= r_hcount + HW'(1);
      end
      if ((r_hcount == '0) && (r_vcount == '0)) begin
        r_mode <= mode;
      end
    end
  end

  // Horizontal segment FSM; also steps the grey-bar index inside ACTIVE.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg    <= SEG_SYNC;
      r_bar    <= 3'd0;
      r_bar_px <= '0;
    end else begin
      case (r_seg)
        SEG_SYNC: begin
          if (r_hcount == HW'(H_SYNC - 1)) r_seg <= SEG_BACK;
        end
        SEG_BACK: begin
          if (r_hcount == HW'(X0 - 1)) begin
            r_seg    <= SEG_ACTIVE;
            r_bar    <= 3'd0;
            r_bar_px <= '0;
          end
        end
        SEG_ACTIVE: begin
          if (r_bar_px == HW'(BAR_W - 1)) begin
            r_bar_px <= '0;
            if (r_bar != 3'd7) r_bar <= r_bar + 3'd1;
          end else begin
            r_bar_px <= r_bar_px + HW'(1);
          end
          if (r_hcount == HW'(ACT_END - 1)) r_seg <= SEG_FRONT;
        end
        SEG_FRONT: begin
          if (w_h_wrap) r_seg <= SEG_SYNC;
        end
        default: r_seg <= SEG_SYNC;
      endcase
    end
  end

  // Output registers.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_sample <= SW'(SYNC_LEVEL);
      r_sol    <= 1'b0;
      r_sof    <= 1'b0;
    end else begin
      r_sample <= w_sample;
      r_sol    <= (r_hcount == '0);
      r_sof    <= (r_hcount == '0) && (r_vcount == '0);
    end
  end

  assign sample_out = r_sample;
  assign sol        = r_sol;
  assign sof        = r_sof;

endmodule

// File: tb/tb_cvbs_timing_gen.sv
// Bench for cvbs_timing_gen: per-cycle scoreboard against a raster model, a table
// of spot values, and hand sequences for startup, field period and mid-line reset.
module tb_cvbs_timing_gen;

  localparam int HT    = 914;
  localparam int VT    = 24;
  localparam int FIELD = HT * VT;
  localparam int HT_B  = 100;
  localparam int VT_B  = 40;
  localparam int RUN   = 3 * FIELD + 10 * HT + 300;
  localparam int NV    = 36;

  logic       pclk = 1'b0;
  logic       rst_n;
  logic [1:0] mode;
  logic [1:0] mode_b;
  logic [7:0] sample_out, sample_b;
  logic       sol, sof, sol_b, sof_b;

  cvbs_timing_gen #(.V_TOTAL(VT)) dut (
    .pclk(pclk), .rst_n(rst_n), .mode(mode),
    .sample_out(sample_out), .sol(sol), .sof(sof)
  );

  cvbs_timing_gen #(
    .H_TOTAL(HT_B), .H_SYNC(8), .H_PORCH(12), .H_FRONT(4), .EQ_WIDTH(4),
    .BROAD_WIDTH(40), .V_TOTAL(VT_B), .BLACK_LEVEL(230)
  ) dut_b (
    .pclk(pclk), .rst_n(rst_n), .mode(mode_b),
    .sample_out(sample_b), .sol(sol_b), .sof(sof_b)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic [7:0] s;
    logic       l;
    logic       f;
    int         h;
    int         v;
    int         fld;
  } exp_t;

  typedef struct {
    int         inst;
    int         fld;
    int         v;
    int         h;
    logic [7:0] exp;
    logic [7:0] got;
    bit         seen;
  } vec_t;

  exp_t sb[$];
  vec_t tbl [NV];
  int   n_pass = 0;
  int   n_tot  = 0;

  task automatic chk(input string nm, input int got, input int exp);
    n_tot++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
  endtask

  // Raster model for the default 914-clock line with a 24-line field.
  function automatic int exp_main(input int h, input int v, input int m);
    int x, y, r;
    if (v < 3) return ((h < 428) || (h >= 457 && h < 885)) ? 0 : 77;
    if (v < 5 || v >= VT - 3) return ((h < 28) || (h >= 457 && h < 485)) ? 0 : 77;
    if (h < 56) return 0;
    if (h < 169 || h >= 890) return 77;
    x = h - 169;
    y = v - 5;
    case (m)
      1: r = 77 + y;
      2: r = 77 + (x / 4);
      3: r = 255 - ((x / 90 > 7) ? 7 : x / 90) * 25;
      default: r = 77;
    endcase
    return (r > 255) ? 255 : r;
  endfunction

  task automatic setv(input int i, input int inst, input int fld, input int v,
                      input int h, input int e);
    tbl[i] = '{inst, fld, v, h, 8'(e), 8'd0, 1'b0};
  endtask

  initial begin
    int   cyc, h, v, fld, m_mode, first_sof, second_sof;
    exp_t e;

    setv(0, 0,0,10,55,0);    setv(1, 0,0,10,56,77);   setv(2, 0,0,10,913,77);
    setv(3, 0,0,0,427,0);    setv(4, 0,0,0,428,77);   setv(5, 0,0,0,456,77);
    setv(6, 0,0,0,457,0);    setv(7, 0,0,0,884,0);    setv(8, 0,0,0,885,77);
    setv(9, 0,0,3,27,0);     setv(10,0,0,3,28,77);    setv(11,0,0,3,457,0);
    setv(12,0,0,3,485,77);   setv(13,0,0,22,0,0);     setv(14,0,0,22,28,77);
    setv(15,0,0,15,400,77);  setv(16,0,1,5,168,77);   setv(17,0,1,5,169,255);
    setv(18,0,1,10,258,255); setv(19,0,1,10,259,230); setv(20,0,1,10,800,80);
    setv(21,0,1,10,889,80);  setv(22,0,1,10,890,77);  setv(23,0,1,20,259,230);
    setv(24,0,2,5,569,177);  setv(25,0,2,5,173,78);
    setv(26,1,0,15,5,0);     setv(27,1,0,15,10,230);  setv(28,1,0,10,50,235);
    setv(29,1,0,15,50,240);  setv(30,1,0,31,50,255);  setv(31,1,0,35,50,255);
    setv(32,1,0,0,39,0);     setv(33,1,0,0,40,230);   setv(34,1,0,3,3,0);
    setv(35,1,0,3,4,230);

    rst_n  = 1'b0;
    mode   = 2'd0;
    mode_b = 2'd1;
    repeat (5) @(posedge pclk);
    @(negedge pclk);
    chk("reset_a", int'({sample_out, sol, sof}), 0);
    chk("reset_b", int'({sample_b, sol_b, sof_b}), 0);
    rst_n = 1'b1;

    m_mode     = 0;
    first_sof  = -1;
    second_sof = -1;
    for (cyc = 0; cyc < RUN; cyc++) begin
      @(posedge pclk);
      h   = cyc % HT;
      v   = (cyc / HT) % VT;
      fld = cyc / FIELD;
      if (h == 0 && v == 0) m_mode = int'(mode);
      sb.push_back('{8'(exp_main(h, v, m_mode)), (h == 0), (h == 0 && v == 0), h, v, fld});
      @(negedge pclk);
      if (sb.size() == 0) begin
        chk("sb_empty", 1, 0);
      end else begin
        e = sb.pop_front();
        chk($sformatf("sb f%0d v%0d h%0d", e.fld, e.v, e.h),
            int'({sample_out, sol, sof}), int'({e.s, e.l, e.f}));
      end
      if (sof) begin
        if (first_sof < 0) first_sof = cyc;
        else if (second_sof < 0) second_sof = cyc;
      end
      for (int i = 0; i < NV; i++) begin
        if (tbl[i].inst == 0 && tbl[i].fld == fld && tbl[i].v == v && tbl[i].h == h) begin
          tbl[i].got  = sample_out;
          tbl[i].seen = 1'b1;
        end
        if (tbl[i].inst == 1 && cyc < HT_B * VT_B && tbl[i].v == cyc / HT_B &&
            tbl[i].h == cyc % HT_B) begin
          tbl[i].got  = sample_b;
          tbl[i].seen = 1'b1;
        end
      end
      if (h == 500 && v == 12 && fld == 0) mode = 2'd3;
      if (h == 500 && v == 12 && fld == 1) mode = 2'd2;
    end

    for (int i = 0; i < NV; i++) begin
      chk($sformatf("vec%0d i%0d f%0d v%0d h%0d", i, tbl[i].inst, tbl[i].fld,
                    tbl[i].v, tbl[i].h),
          tbl[i].seen ? int'(tbl[i].got) : -1, int'(tbl[i].exp));
    end
    chk("first_sof_cycle", first_sof, 0);
    chk("sof_period", second_sof - first_sof, FIELD);

    // Mid-line reset: field 3 line 10, pixel x=131 in mode 2.
    @(posedge pclk);
    #1;
    chk("pre_reset_sample", int'(sample_out), 109);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset_out", int'({sample_out, sol, sof}), 0);
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    chk("held_reset_out", int'({sample_out, sol, sof}), 0);
    rst_n = 1'b1;
    @(negedge pclk);
    chk("restart_first", int'({sample_out, sol, sof}), 3);
    @(negedge pclk);
    chk("restart_second", int'({sample_out, sol, sof}), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/cvbs_timing_gen.md
# cvbs_timing_gen

Parametrised composite-video timing and test-pattern generator. It produces a raw luma sample stream (sync, blanking, active picture) for a DAC on the pixel clock. Line and field geometry, sync widths, sample width and levels are parameters, so the same block covers 625/50 and 525/60 progressive fields. It adds selectable test patterns and line/field strobes for downstream logic.

## Interface
Parameters:
- SW, 8: sample width in bits
- H_TOTAL, 914: pixel clocks per line; must be even
- H_SYNC, 56: normal line-sync width
- H_PORCH, 113: back porch after line sync
- H_FRONT, 24: front porch at end of line
- EQ_WIDTH, 28: equalising pulse width
- BROAD_WIDTH, 428: broad (vertical) pulse width
- V_TOTAL, 312: lines per field
- V_BROAD, 3: broad-pulse lines at field start
- V_PRE_EQ, 2: equalising lines after the broad lines
- V_POST_EQ, 3: equalising lines at field end
- SYNC_LEVEL, 0; BLACK_LEVEL, 77; WHITE_LEVEL, 255: output codes
- RAMP_SHIFT, 2: horizontal ramp slope, in pixels per code step as a power of 2

Ports:
- pclk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- mode  in  2  pattern: 0 flat black, 1 vertical ramp, 2 horizontal ramp, 3 grey bars
- sample_out  out  SW  video sample, registered
- sol  out  1  one-cycle strobe at the start of each line
- sof  out  1  one-cycle strobe at the start of each field

## Operation
- hcount runs 0..H_TOTAL-1 and wraps. vcount increments on hcount wrap and runs 0..V_TOTAL-1. Counter widths are $clog2 of the total.
- Line type is decoded from vcount and registered at hcount wrap:
  - BROAD: vcount < V_BROAD
  - EQ: V_BROAD ≤ vcount < V_BROAD+V_PRE_EQ, or vcount ≥ V_TOTAL-V_POST_EQ
  - NORMAL: all other lines
- Let HALF = H_TOTAL/2. BROAD and EQ lines carry two pulses, at hcount 0 and at hcount HALF. Pulse width is BROAD_WIDTH or EQ_WIDTH respectively; the rest of the line is BLACK_LEVEL.
- NORMAL lines use a segment FSM with states SYNC, BACK, ACTIVE and FRONT:
  - SYNC: hcount 0..H_SYNC-1, outputs SYNC_LEVEL
  - BACK: up to H_SYNC+H_PORCH-1, outputs BLACK_LEVEL
  - ACTIVE: up to H_TOTAL-H_FRONT-1, outputs the pattern
  - FRONT: to the end of the line, outputs BLACK_LEVEL
  - Transitions are taken on segment-end compares only. FRONT goes to SYNC at hcount wrap.
- Active coordinates:
  - x = hcount-(H_SYNC+H_PORCH)
  - y = vcount-(V_BROAD+V_PRE_EQ)
  - A_W = H_TOTAL-H_SYNC-H_PORCH-H_FRONT
  - localparams: BAR_W = A_W/8 and STEP = (WHITE_LEVEL-BLACK_LEVEL)/7
- Patterns; all sums are computed at SW+1 bits or wider and saturate at WHITE_LEVEL:
  - mode 0: BLACK_LEVEL
  - mode 1: BLACK_LEVEL + y
  - mode 2: BLACK_LEVEL + (x >> RAMP_SHIFT)
  - mode 3: WHITE_LEVEL - bar*STEP
    - bar is a 3-bit index held by a counter and reset to 0 at ACTIVE entry.
    - bar increments every BAR_W pixels and holds at 7 once reached; no wrap.
- mode is latched into an internal register at the first cycle of each field (vcount=0, hcount=0). Changes mid-field have no effect until the next field.
- A parameter set violating H_SYNC+H_PORCH+H_FRONT < H_TOTAL or BROAD_WIDTH < HALF is illegal. The block checks this with elaboration-time $error.

## Timing
- Reset (rst_n low, asynchronous):
  - hcount=0, vcount=0, segment FSM in SYNC, line type BROAD, latched mode=0
  - sample_out=SYNC_LEVEL, sol=0, sof=0
- After rst_n deasserts, the first rising edge processes hcount=0, vcount=0.
- Latency: sample_out, sol and sof are registered. The value for counter position (h,v) appears on the edge after that position is processed.
- sol is high for exactly one cycle per line, aligned with the sample_out of hcount=0. sof coincides with sol on vcount=0.
- Field wrap: after (H_TOTAL-1, V_TOTAL-1) comes (0,0) with no extra cycle. The field period is exactly H_TOTAL*V_TOTAL clocks.
- Reset asserted mid-line: outputs go to their reset values immediately, with no partial-line completion.

## Test plan
- **Reset/startup:** hold rst_n low 5 cycles, release, mode=0.
  - Expect sample_out=0 during reset.
  - First sol=sof=1 one cycle after release.
  - Next sof exactly 285168 cycles later with defaults.
- **Normal line, defaults, mode 0:** on vcount=10, sample_out is:
  - 0 for 56 cycles
  - then 77 for the remaining 858 cycles
  - sol once per 914 cycles
- **Broad/EQ lines:**
  - vcount=0: 0 for 428 cycles, 77 for 29, 0 for 428, 77 for 29.
  - vcount=3 and vcount=310: 0 for 28, 77 for 429, 0 for 28, 77 for 429.
- **Bars, mode 3:** A_W=721, BAR_W=90, STEP=25.
  - Active segment levels are 255, 230, 205, …, 80, in steps of 90 pixels.
  - The last bar holds 80 through pixel 720.
- **Ramps:**
  - mode 2: pixel x=400 gives 177.
  - mode 1, line y=200: 255 (saturated, not 21).
- **Mode change mid-field:** switch 0→3 at vcount=100.
  - Rest of field stays 77 in active.
  - Bars appear from the first active line of the next field.
